// File: rtl/key_debounce_if.sv
// Key conditioner signal bundle: raw active-low key pins in, debounced level and event pulses out.
interface key_debounce_if #(
    parameter int KEY_W = 4
);
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic [KEY_W-1:0] key_long;

    modport master (
        output key_in,
        input  key_out,
        input  key_press,
        input  key_release,
        input  key_long
    );

    modport slave (
        input  key_in,
        output key_out,
        output key_press,
        output key_release,
        output key_long
    );
endinterface

// File: rtl/key_debounce.sv
// Push-button front end: 2-FF sync, per-key debounce FSM, clean active-low level
// plus one-cycle press / release / long-press pulses.
//
// state    | meaning
// IDLE     | key released and accepted as released
// PRESS_DB | key seen low, waiting DEBOUNCE_CNT stable cycles
// HELD     | press accepted, long-press counter running
// REL_DB   | key seen high, waiting DEBOUNCE_CNT stable cycles
module key_debounce #(
    parameter int KEY_W        = 4,
    parameter int DEBOUNCE_CNT = 1_000_000,
    parameter int LONG_CNT     = 50_000_000
) (
    input logic           sys_clk,
    input logic           sys_rst_n,
    key_debounce_if.slave kb
);
    localparam int DW = $clog2(DEBOUNCE_CNT);
    localparam int LW = $clog2(LONG_CNT);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CNT - 1);
    localparam logic [LW-1:0] L_LAST = LW'(LONG_CNT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } state_e;

    logic [KEY_W-1:0] sync1_q;
    logic [KEY_W-1:0] sync2_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= kb.key_in;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < KEY_W; g++) begin : g_key
        state_e        state_q, state_d;
        logic [DW-1:0] dcnt_q, dcnt_d;
        logic [LW-1:0] lcnt_q, lcnt_d;
        logic          fired_q, fired_d;
        logic          key_out_q, key_out_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          long_q, long_d;
        logic          s;

        assign s = sync2_q[g];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state_q   <= IDLE;
                dcnt_q    <= '0;
                lcnt_q    <= '0;
                fired_q   <= 1'b0;
                key_out_q <= 1'b1;
                press_q   <= 1'b0;
                rel_q     <= 1'b0;
                long_q    <= 1'b0;
            end else begin
                state_q   <= state_d;
                dcnt_q    <= dcnt_d;
                lcnt_q    <= lcnt_d;
                fired_q   <= fired_d;
                key_out_q <= key_out_d;
                press_q   <= press_d;
                rel_q     <= rel_d;
                long_q    <= long_d;
            end
        end

        always_comb begin
            state_d = state_q;
            case (state_q)
                IDLE:     if (!s) state_d = PRESS_DB;
                PRESS_DB: begin
                    if (s)                    state_d = IDLE;
                    else if (dcnt_q == D_LAST) state_d = HELD;
                end
                HELD:     if (s) state_d = REL_DB;
                REL_DB: begin
                    if (!s)                   state_d = HELD;
                    else if (dcnt_q == D_LAST) state_d = IDLE;
                end
                default:  state_d = IDLE;
            endcase
        end

        always_comb begin
            dcnt_d    = dcnt_q;
            lcnt_d    = lcnt_q;
            fired_d   = fired_q;
            key_out_d = key_out_q;
            press_d   = 1'b0;
            rel_d     = 1'b0;
            long_d    = 1'b0;
            case (state_q)
                IDLE: begin
                    if (!s) dcnt_d = '0;
                end
                PRESS_DB: begin
                    if (s) begin
                        dcnt_d = '0;
                    end else if (dcnt_q == D_LAST) begin
                        key_out_d = 1'b0;
                        press_d   = 1'b1;
                        lcnt_d    = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                HELD: begin
                    if (s) begin
                        dcnt_d = '0;
                    end else if (lcnt_q == L_LAST) begin
                        // lcnt parks at its last value; the fired flag limits long to once per press
                        if (!fired_q) begin
                            long_d  = 1'b1;
                            fired_d = 1'b1;
                        end
                    end else begin
                        lcnt_d = lcnt_q + 1'b1;
                    end
                end
                REL_DB: begin
                    if (s) begin
                        if (dcnt_q == D_LAST) begin
                            key_out_d = 1'b1;
                            rel_d     = 1'b1;
                            fired_d   = 1'b0;
                        end else begin
                            dcnt_d = dcnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        assign kb.key_out[g]     = key_out_q;
        assign kb.key_press[g]   = press_q;
        assign kb.key_release[g] = rel_q;
        assign kb.key_long[g]    = long_q;
    end
endmodule
